// File: rtl/i2s_rx_framer_if.sv
// Sample stream from the I2S receive framer to the audio driver interface.
// Master drives valid/data, slave returns ready; transfer on valid && ready at posedge clk.
interface i2s_rx_framer_if #(
    parameter int unsigned DATA_SIZE = 28
) ();
    logic                 source_valid;
    logic [DATA_SIZE-1:0] source_data;
    logic                 source_ready;

    modport master (
        output source_valid,
        output source_data,
        input  source_ready
    );

    modport slave (
        input  source_valid,
        input  source_data,
        output source_ready
    );
endinterface

// File: rtl/i2s_rx_framer.sv
// I2S receive framer: oversamples BCLK/LRCLK/SDATA in the clk domain and queues tagged words.
// Define I2S_RX_SEQ_TAG_EN to carry a 3-bit sequence tag in word bits [26:24].
module i2s_rx_framer #(
    parameter int unsigned SAMPLE_BITS = 24,
    parameter int unsigned DATA_SIZE   = 28,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic                   i2s_bclk,
    input  logic                   i2s_lrclk,
    input  logic                   i2s_sdata,
    i2s_rx_framer_if.master        src,
    output logic                   overflow,
    input  logic                   clear_overflow
);

    localparam int unsigned CNT_W = (SAMPLE_BITS > 1) ? $clog2(SAMPLE_BITS) : 1;
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned OCC_W = PTR_W + 1;
    localparam int unsigned TAG_W = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SKIP  = 2'd1,
        S_SHIFT = 2'd2,
        S_WAIT  = 2'd3
    } state_t;

    // Input synchronisers plus BCLK history for edge detection
    logic bclk_s1, bclk_s2, bclk_d;
    logic lr_s1, lr_s2, lr_prev;
    logic sd_s1, sd_s2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bclk_s1 <= 1'b0;
            bclk_s2 <= 1'b0;
            bclk_d  <= 1'b0;
            lr_s1   <= 1'b0;
            lr_s2   <= 1'b0;
            sd_s1   <= 1'b0;
            sd_s2   <= 1'b0;
        end else begin
            bclk_s1 <= i2s_bclk;
            bclk_s2 <= bclk_s1;
            bclk_d  <= bclk_s2;
            lr_s1   <= i2s_lrclk;
            lr_s2   <= lr_s1;
            sd_s1   <= i2s_sdata;
            sd_s2   <= sd_s1;
        end
    end

    logic strobe_c;
    logic lr_change_c;

    assign strobe_c    = bclk_s2 & ~bclk_d;
    assign lr_change_c = strobe_c & (lr_s2 != lr_prev);

    // Word select as seen at the previous bit strobe
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lr_prev <= 1'b0;
        end else if (strobe_c) begin
            lr_prev <= lr_s2;
        end
    end

    state_t             state, state_nx;
    logic [CNT_W-1:0]   bit_cnt;
    logic [SAMPLE_BITS-1:0] sample;
    logic               frame_ch;
    logic               last_bit_c;
    logic               push_c;
    logic               shift_c;
    logic               restart_c;

    assign last_bit_c = (bit_cnt == CNT_W'(SAMPLE_BITS - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        if (!enable) begin
            state_nx = S_IDLE;
        end else if (strobe_c) begin
            case (state)
                S_IDLE:  if (lr_change_c) state_nx = S_SKIP;
                S_SKIP:  state_nx = lr_change_c ? S_SKIP : S_SHIFT;
                S_SHIFT: begin
                    if (lr_change_c)     state_nx = S_SKIP;
                    else if (last_bit_c) state_nx = S_WAIT;
                end
                S_WAIT:  if (lr_change_c) state_nx = S_SKIP;
                default: state_nx = S_IDLE;
            endcase
        end
    end

    // A word select change anywhere restarts the slot; a change mid-SHIFT discards the partial sample
    always_comb begin
        push_c    = 1'b0;
        shift_c   = 1'b0;
        restart_c = 1'b0;
        if (enable && strobe_c) begin
            case (state)
                S_SHIFT: begin
                    if (lr_change_c) begin
                        restart_c = 1'b1;
                    end else begin
                        shift_c = 1'b1;
                        push_c  = last_bit_c;
                    end
                end
                default: restart_c = lr_change_c;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_ch <= 1'b0;
            bit_cnt  <= '0;
            sample   <= '0;
        end else begin
            if (restart_c) begin
                frame_ch <= lr_s2;
            end
            if (state == S_SKIP) begin
                bit_cnt <= '0;
            end else if (shift_c) begin
                bit_cnt <= bit_cnt + CNT_W'(1);
                sample  <= {sample[SAMPLE_BITS-2:0], sd_s2};
            end
        end
    end

    logic [TAG_W-1:0] tag_c;

`ifdef I2S_RX_SEQ_TAG_EN
    logic [TAG_W-1:0] tag_q;

    // Counts every completed slot, including words later dropped on overflow
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_q <= '0;
        end else if (push_c) begin
            tag_q <= tag_q + TAG_W'(1);
        end
    end

    assign tag_c = tag_q;
`else
    assign tag_c = '0;
`endif

    logic [DATA_SIZE-1:0] word_c;

    assign word_c = DATA_SIZE'({frame_ch, tag_c, sample[SAMPLE_BITS-2:0], sd_s2});

    logic [DATA_SIZE-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr, rd_nx_c;
    logic [OCC_W-1:0]     occ, occ_nx_c, remain_c;
    logic                 pop_c, full_c, wr_en_c, drop_c;
    logic [DATA_SIZE-1:0] head_c;

    assign pop_c    = src.source_valid & src.source_ready;
    assign full_c   = (occ == OCC_W'(FIFO_DEPTH));
    assign wr_en_c  = push_c & (~full_c | pop_c);
    assign drop_c   = push_c & full_c & ~pop_c;
    assign rd_nx_c  = rd_ptr + PTR_W'(pop_c);
    assign remain_c = occ - OCC_W'(pop_c);
    assign occ_nx_c = remain_c + OCC_W'(wr_en_c);

    // Next head: surviving entry if any, otherwise the word written into an empty queue
    always_comb begin
        head_c = '0;
        if (remain_c != '0) begin
            head_c = mem[rd_nx_c];
        end else if (wr_en_c) begin
            head_c = word_c;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem[wr_ptr] <= word_c;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            occ              <= '0;
            src.source_valid <= 1'b0;
            src.source_data  <= '0;
        end else begin
            if (wr_en_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            rd_ptr           <= rd_nx_c;
            occ              <= occ_nx_c;
            src.source_valid <= (occ_nx_c != '0);
            src.source_data  <= head_c;
        end
    end

    // Sticky drop flag; a new drop takes priority over a clear in the same cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow <= 1'b0;
        end else if (drop_c) begin
            overflow <= 1'b1;
        end else if (clear_overflow) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_i2s_rx_framer.sv
// Directed bench for i2s_rx_framer: drives I2S slots, records handshakes, checks words and flags.
module tb_i2s_rx_framer;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic rst, enable, bclk, lrclk, sdata, overflow, clear_overflow;

    i2s_rx_framer_if #(.DATA_SIZE(28)) src_if ();

    i2s_rx_framer #(
        .SAMPLE_BITS(24),
        .DATA_SIZE  (28),
        .FIFO_DEPTH (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .i2s_bclk      (bclk),
        .i2s_lrclk     (lrclk),
        .i2s_sdata     (sdata),
        .src           (src_if),
        .overflow      (overflow),
        .clear_overflow(clear_overflow)
    );

    int checks = 0;
    int passed = 0;
    int fails  = 0;
    int unsigned cyc = 0;
    logic [27:0] got_q [$];
    int unsigned cyc_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst && src_if.source_valid && src_if.source_ready) begin
            got_q.push_back(src_if.source_data);
            cyc_q.push_back(cyc);
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: observed no finish, expected finish before 5ms");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [27:0] exp_word(input logic ch, input logic [2:0] tag, input logic [23:0] s);
        logic [2:0] t;
        t = tag;
`ifndef I2S_RX_SEQ_TAG_EN
        t = 3'b000;
`endif
        return {ch, t, s};
    endfunction

    // Slot bit i: bit 0 carries the word select change, bit 1 is skipped, bits 2..25 are MSB-first data
    task automatic send_bits(input logic ch, input logic [23:0] s, input int first, input int last,
                             input bit pop_at_push = 1'b0);
        for (int i = first; i <= last; i++) begin
            @(posedge clk); #2;
            bclk  = 1'b0;
            lrclk = ch;
            sdata = (i >= 2 && i < 26) ? s[25 - i] : 1'b0;
            repeat (4) @(posedge clk);
            #2 bclk = 1'b1;
            if (pop_at_push && i == 25) begin
                repeat (2) @(posedge clk);
                #2 src_if.source_ready = 1'b1;
                @(posedge clk);
                #2 src_if.source_ready = 1'b0;
            end else begin
                repeat (3) @(posedge clk);
            end
        end
    endtask

    task automatic wait_words(input string tag, input int n);
        int k;
        k = 0;
        while (got_q.size() < n && k < 3000) begin
            @(negedge clk);
            k++;
        end
        repeat (10) @(negedge clk);
        check(tag, 32'(got_q.size()), 32'(n));
    endtask

    task automatic set_ready(input logic r);
        @(posedge clk); #2 src_if.source_ready = r;
    endtask

    logic [23:0] s2 [6] = '{24'h111111, 24'h222222, 24'h333333, 24'h444444, 24'h555555, 24'h666666};
    logic [23:0] s5 [5] = '{24'hA1B2C3, 24'hD4E5F6, 24'h0F1E2D, 24'h3C4B5A, 24'h796857};

    initial begin
        rst = 1'b0; enable = 1'b1; bclk = 1'b0; lrclk = 1'b0; sdata = 1'b0;
        clear_overflow = 1'b0; src_if.source_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_valid", 32'(src_if.source_valid), 32'h0);
        check("reset_data", 32'(src_if.source_data), 32'h0);
        check("reset_overflow", 32'(overflow), 32'h0);
        @(posedge clk); #2 rst = 1'b1;

        // Basic stereo capture
        src_if.source_ready = 1'b1;
        send_bits(1'b1, 24'h0, 0, 3);
        send_bits(1'b0, 24'hABCDEF, 0, 31);
        send_bits(1'b1, 24'h123456, 0, 31);
        wait_words("t1_count", 2);
        check("t1_left", 32'(got_q[0]), 32'(exp_word(1'b0, 3'd0, 24'hABCDEF)));
        check("t1_right", 32'(got_q[1]), 32'(exp_word(1'b1, 3'd1, 24'h123456)));
        got_q.delete(); cyc_q.delete();

        // Reset mid-frame with a word queued
        set_ready(1'b0);
        send_bits(1'b0, 24'h5A5A5A, 0, 31);
        send_bits(1'b1, 24'hC3C3C3, 0, 11);
        @(negedge clk);
        check("rst_pre_valid", 32'(src_if.source_valid), 32'h1);
        rst = 1'b0;
        #1;
        check("rst_valid", 32'(src_if.source_valid), 32'h0);
        check("rst_data", 32'(src_if.source_data), 32'h0);
        check("rst_overflow", 32'(overflow), 32'h0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;

        // Backpressure for six slots: four queued, two dropped
        send_bits(1'b1, 24'h0, 0, 3);
        for (int i = 0; i < 6; i++) send_bits(1'(i % 2), s2[i], 0, 31);
        @(negedge clk);
        check("bp_overflow", 32'(overflow), 32'h1);
        check("bp_valid", 32'(src_if.source_valid), 32'h1);
        check("bp_head_hold", 32'(src_if.source_data), 32'(exp_word(1'b0, 3'd0, s2[0])));
        set_ready(1'b1);
        wait_words("bp_drain_count", 4);
        for (int i = 0; i < 4; i++)
            check($sformatf("bp_word%0d", i), 32'(got_q[i]), 32'(exp_word(1'(i % 2), 3'(i), s2[i])));
        for (int i = 0; i < 3; i++)
            check($sformatf("bp_gap%0d", i), cyc_q[i + 1] - cyc_q[i], 32'd1);
        check("bp_overflow_sticky", 32'(overflow), 32'h1);
        @(posedge clk); #2 clear_overflow = 1'b1;
        @(posedge clk); #2 clear_overflow = 1'b0;
        @(negedge clk);
        check("ovf_cleared", 32'(overflow), 32'h0);
        got_q.delete(); cyc_q.delete();
        send_bits(1'b0, 24'hFEDCBA, 0, 31);
        wait_words("tag6_count", 1);
        check("tag6_word", 32'(got_q[0]), 32'(exp_word(1'b0, 3'd6, 24'hFEDCBA)));
        got_q.delete(); cyc_q.delete();

        // Short slot: word select toggles after 10 data bits
        send_bits(1'b1, 24'h777777, 0, 11);
        send_bits(1'b0, 24'h0C0FFE, 0, 31);
        wait_words("short_count", 1);
        check("short_next", 32'(got_q[0]), 32'(exp_word(1'b0, 3'd7, 24'h0C0FFE)));
        got_q.delete(); cyc_q.delete();

        // Enable dropped mid-SHIFT with two words queued
        set_ready(1'b0);
        send_bits(1'b1, 24'h9ABCDE, 0, 31);
        send_bits(1'b0, 24'h13579B, 0, 31);
        send_bits(1'b1, 24'hFFFFFF, 0, 13);
        enable = 1'b0;
        send_bits(1'b1, 24'hFFFFFF, 14, 19);
        enable = 1'b1;
        send_bits(1'b1, 24'hFFFFFF, 20, 31);
        @(negedge clk);
        check("en_queued_valid", 32'(src_if.source_valid), 32'h1);
        set_ready(1'b1);
        wait_words("en_drain_count", 2);
        check("en_word0", 32'(got_q[0]), 32'(exp_word(1'b1, 3'd0, 24'h9ABCDE)));
        check("en_word1", 32'(got_q[1]), 32'(exp_word(1'b0, 3'd1, 24'h13579B)));
        got_q.delete(); cyc_q.delete();
        send_bits(1'b0, 24'h2468AC, 0, 31);
        wait_words("en_resume_count", 1);
        check("en_resume_word", 32'(got_q[0]), 32'(exp_word(1'b0, 3'd2, 24'h2468AC)));
        got_q.delete(); cyc_q.delete();

        // Full FIFO with pop and push on the same edge
        set_ready(1'b0);
        for (int i = 0; i < 4; i++) send_bits(1'((i + 1) % 2), s5[i], 0, 31);
        @(negedge clk);
        check("full_no_ovf", 32'(overflow), 32'h0);
        send_bits(1'b1, s5[4], 0, 31, 1'b1);
        @(negedge clk);
        check("pp_overflow", 32'(overflow), 32'h0);
        check("pp_popped", 32'(got_q.size()), 32'd1);
        set_ready(1'b1);
        wait_words("pp_drain_count", 5);
        for (int i = 0; i < 5; i++)
            check($sformatf("pp_word%0d", i), 32'(got_q[i]),
                  32'(exp_word(1'((i + 1) % 2), 3'(i + 3), s5[i])));
        check("pp_overflow_end", 32'(overflow), 32'h0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
